// File: rtl/mem_req_pkg.sv
// mem_req_pkg
//   Shared types and helpers for the memory request initiator:
//   access size encoding, the in-flight request record, the response
//   record, and the byte-enable / load-extension helpers.
package mem_req_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE  = 2'd0,
        SIZE_HALF  = 2'd1,
        SIZE_WORD  = 2'd2,
        SIZE_DWORD = 2'd3
    } mem_size_e;

    // Bookkeeping for the single command between issue and response push.
    typedef struct packed {
        logic      valid;
        logic      we;
        mem_size_e size;
        logic [2:0] offset;
        logic      sign;
        logic      err;
    } inflight_t;

    typedef struct packed {
        logic [63:0] rdata;
        logic        err;
    } rsp_t;

    // Byte lanes covered by an access of the given size at offset 0.
    function automatic logic [7:0] size_mask(input mem_size_e size);
        logic [7:0] m;
        case (size)
            SIZE_BYTE: m = 8'h01;
            SIZE_HALF: m = 8'h03;
            SIZE_WORD: m = 8'h0F;
            default:   m = 8'hFF;
        endcase
        return m;
    endfunction

    // Low address bits that must be zero for a naturally aligned access.
    function automatic logic [2:0] align_low(input mem_size_e size);
        logic [2:0] a;
        case (size)
            SIZE_BYTE: a = 3'd0;
            SIZE_HALF: a = 3'd1;
            SIZE_WORD: a = 3'd3;
            default:   a = 3'd7;
        endcase
        return a;
    endfunction

    function automatic logic [7:0] be_calc(input mem_size_e size, input logic [2:0] offset);
        logic [7:0] m;
        m = size_mask(size);
        return m << offset;
    endfunction

    // Keep the low bytes of an already-right-shifted load and extend them.
    function automatic logic [63:0] extend_load(input logic [63:0] raw,
                                                input mem_size_e   size,
                                                input logic        sign);
        logic [63:0] r;
        case (size)
            SIZE_BYTE: r = {{56{sign & raw[7]}},  raw[7:0]};
            SIZE_HALF: r = {{48{sign & raw[15]}}, raw[15:0]};
            SIZE_WORD: r = {{32{sign & raw[31]}}, raw[31:0]};
            default:   r = raw;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_req_rsp_fifo.sv
// mem_req_rsp_fifo
//   Synchronous response FIFO, DEPTH entries, storage in flops so the head
//   entry never depends combinationally on the push side.
//   Ports:
//     clk, rst        clock, synchronous active-high reset (empties FIFO)
//     push, push_data write one response
//     pop             remove the head entry (ignored when empty)
//     head            current head entry (valid when count != 0)
//     count           number of stored entries
//   A push on a full FIFO is accepted when a pop happens in the same cycle.
module mem_req_rsp_fifo
    import mem_req_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  rsp_t          push_data,
    input  logic          pop,
    output rsp_t          head,
    output logic [CW-1:0] count
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    rsp_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mem_req_initiator.sv
// mem_req_initiator
//   Turns load/store commands into single-cycle data-interface requests and
//   returns one in-order response per command through a response FIFO.
//   Ports:
//     clk_i, rst_i              clock, synchronous active-high reset
//     cmd_*                     command channel (valid/ready handshake)
//     rsp_*                     response channel (valid/ready handshake)
//     data_if_*_o               memory request, issued combinationally
//     data_if_data_rvalid_i/_rdata_i  memory reply, one cycle after request
//   Configuration macro: MEM_REQ_INITIATOR_MISALIGN_CHECK_EN
//     defined   -> misaligned commands make no access and respond err=1
//     undefined -> low address bits are cleared to the access alignment,
//                  rsp_err_o is tied 0
module mem_req_initiator
    import mem_req_pkg::*;
#(
    parameter int unsigned RSP_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [63:0] cmd_addr_i,
    input  logic        cmd_we_i,
    input  logic [1:0]  cmd_size_i,
    input  logic        cmd_signed_i,
    input  logic [63:0] cmd_wdata_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [63:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic [63:0] data_if_address_o,
    output logic        data_if_data_req_o,
    output logic [7:0]  data_if_data_be_o,
    output logic [63:0] data_if_data_wdata_o,
    output logic        data_if_data_we_o,
    input  logic        data_if_data_rvalid_i,
    input  logic [63:0] data_if_data_rdata_i
);

    localparam int unsigned CW = $clog2(RSP_DEPTH + 1);

    mem_size_e     size;
    logic [2:0]    low_mask;
    logic [2:0]    offset;
    logic          misaligned;
    logic          accept;
    logic          issue;
    inflight_t     inflight;
    logic          push;
    rsp_t          push_data;
    rsp_t          head;
    logic [CW-1:0] fifo_count;
    logic [CW:0]   occupancy;
    logic          pop;

    assign size     = mem_size_e'(cmd_size_i);
    assign low_mask = align_low(size);

`ifdef MEM_REQ_INITIATOR_MISALIGN_CHECK_EN
    assign misaligned = |(cmd_addr_i[2:0] & low_mask);
    assign offset     = cmd_addr_i[2:0];
`else
    assign misaligned = 1'b0;
    assign offset     = cmd_addr_i[2:0] & ~low_mask;
`endif

    // The in-flight slot reserves a FIFO entry so a response always has room.
    assign occupancy   = {1'b0, fifo_count} + {{CW{1'b0}}, inflight.valid};
    assign cmd_ready_o = ~rst_i & (occupancy < (CW + 1)'(RSP_DEPTH));
    assign accept      = cmd_valid_i & cmd_ready_o;
    assign issue       = accept & ~misaligned;

    assign data_if_address_o    = {cmd_addr_i[63:3], offset};
    assign data_if_data_req_o   = issue;
    assign data_if_data_be_o    = issue ? be_calc(size, offset) : '0;
    assign data_if_data_we_o    = issue & cmd_we_i;
    assign data_if_data_wdata_o = cmd_wdata_i << {offset, 3'b000};

    // Holds a command for exactly the cycle its memory reply arrives.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            inflight <= '0;
        end else if (accept) begin
            inflight.valid  <= 1'b1;
            inflight.we     <= cmd_we_i;
            inflight.size   <= size;
            inflight.offset <= offset;
            inflight.sign   <= cmd_signed_i;
            inflight.err    <= misaligned;
        end else begin
            inflight <= '0;
        end
    end

    // Stores and errored commands respond without waiting for rvalid; a
    // stray rvalid with no in-flight entry never pushes.
    assign push = inflight.valid & (inflight.we | inflight.err | data_if_data_rvalid_i);

    always_comb begin
        push_data.err   = inflight.err;
        push_data.rdata = '0;
        if (!inflight.we && !inflight.err) begin
            push_data.rdata = extend_load(data_if_data_rdata_i >> {inflight.offset, 3'b000},
                                          inflight.size, inflight.sign);
        end
    end

    mem_req_rsp_fifo #(
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk       (clk_i),
        .rst       (rst_i),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .count     (fifo_count)
    );

    assign rsp_valid_o = ~rst_i & (fifo_count != '0);
    assign pop         = rsp_valid_o & rsp_ready_i;
    assign rsp_rdata_o = rsp_valid_o ? head.rdata : '0;

`ifdef MEM_REQ_INITIATOR_MISALIGN_CHECK_EN
    assign rsp_err_o = rsp_valid_o & head.err;
`else
    logic unused_head_err;
    assign unused_head_err = head.err;
    assign rsp_err_o       = 1'b0;
`endif

endmodule

// File: tb/tb_mem_req_initiator.sv
// tb_mem_req_initiator
//   Self-checking bench for mem_req_initiator (RSP_DEPTH = 2). Command
//   vectors carry their expected request fields and response; responses are
//   checked in order against a scoreboard queue. Expectations follow
//   MEM_REQ_INITIATOR_MISALIGN_CHECK_EN when it is defined.
module tb_mem_req_initiator;
    import mem_req_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic [63:0] cmd_addr_i;
    logic        cmd_we_i;
    logic [1:0]  cmd_size_i;
    logic        cmd_signed_i;
    logic [63:0] cmd_wdata_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [63:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic [63:0] data_if_address_o;
    logic        data_if_data_req_o;
    logic [7:0]  data_if_data_be_o;
    logic [63:0] data_if_data_wdata_o;
    logic        data_if_data_we_o;
    logic        data_if_data_rvalid_i;
    logic [63:0] data_if_data_rdata_i;

    mem_req_initiator #(
        .RSP_DEPTH (2)
    ) dut (
        .clk_i                 (clk_i),
        .rst_i                 (rst_i),
        .cmd_valid_i           (cmd_valid_i),
        .cmd_ready_o           (cmd_ready_o),
        .cmd_addr_i            (cmd_addr_i),
        .cmd_we_i              (cmd_we_i),
        .cmd_size_i            (cmd_size_i),
        .cmd_signed_i          (cmd_signed_i),
        .cmd_wdata_i           (cmd_wdata_i),
        .rsp_valid_o           (rsp_valid_o),
        .rsp_ready_i           (rsp_ready_i),
        .rsp_rdata_o           (rsp_rdata_o),
        .rsp_err_o             (rsp_err_o),
        .data_if_address_o     (data_if_address_o),
        .data_if_data_req_o    (data_if_data_req_o),
        .data_if_data_be_o     (data_if_data_be_o),
        .data_if_data_wdata_o  (data_if_data_wdata_o),
        .data_if_data_we_o     (data_if_data_we_o),
        .data_if_data_rvalid_i (data_if_data_rvalid_i),
        .data_if_data_rdata_i  (data_if_data_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [63:0] addr;
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [63:0] wdata;
        logic [63:0] mem;
        logic        exp_req;
        logic [7:0]  exp_be;
        logic [63:0] exp_addr;
        logic [63:0] exp_wdata;
        logic [63:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    rsp_t        exp_q[$];
    rsp_t        cur_exp;
    logic [63:0] cur_mem;
    vec_t        vecs[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: record accepted command, check popped response, then act
    // as memory and reply to a load issued this cycle.
    task automatic tick();
        logic rd_issue;
        rsp_t e;
        rd_issue = data_if_data_req_o && !data_if_data_we_o;
        if (cmd_valid_i && cmd_ready_o) exp_q.push_back(cur_exp);
        if (rsp_valid_o && rsp_ready_i) begin
            if (exp_q.size() == 0) begin
                chk("rsp_unexpected", 64'(rsp_valid_o), 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_rdata", rsp_rdata_o, e.rdata);
                chk("rsp_err", 64'(rsp_err_o), 64'(e.err));
            end
        end
        @(posedge clk_i);
        #1;
        data_if_data_rvalid_i = rd_issue;
        data_if_data_rdata_i  = rd_issue ? cur_mem : 64'h0;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_cmd_ready"}, 64'(cmd_ready_o), 64'd0);
        chk({tag, "_req"}, 64'(data_if_data_req_o), 64'd0);
        chk({tag, "_we"}, 64'(data_if_data_we_o), 64'd0);
        chk({tag, "_be"}, 64'(data_if_data_be_o), 64'd0);
        chk({tag, "_rsp_valid"}, 64'(rsp_valid_o), 64'd0);
        chk({tag, "_rsp_err"}, 64'(rsp_err_o), 64'd0);
        chk({tag, "_rsp_rdata"}, rsp_rdata_o, 64'd0);
    endtask

    task automatic set_cmd(input logic [63:0] addr, input logic we, input logic [1:0] size,
                           input logic sgn, input logic [63:0] wdata);
        cmd_valid_i  = 1'b1;
        cmd_addr_i   = addr;
        cmd_we_i     = we;
        cmd_size_i   = size;
        cmd_signed_i = sgn;
        cmd_wdata_i  = wdata;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic exp_rdy [5];
        int unsigned k;
        logic acc;

        //            addr                 we    sz    sg    wdata                  mem                    req   be     exp_addr             exp_wdata              exp_rdata              err
        vecs[0]  = '{64'h0000_0000_8000_0000, 1'b0, 2'd3, 1'b0, 64'h0, 64'h1122_3344_5566_7788, 1'b1, 8'hFF, 64'h0000_0000_8000_0000, 64'h0, 64'h1122_3344_5566_7788, 1'b0};
        vecs[1]  = '{64'h0000_0000_8000_0003, 1'b0, 2'd0, 1'b1, 64'h0, 64'h0000_0000_80FF_FFFF, 1'b1, 8'h08, 64'h0000_0000_8000_0003, 64'h0, 64'hFFFF_FFFF_FFFF_FF80, 1'b0};
        vecs[2]  = '{64'h0000_0000_8000_0006, 1'b1, 2'd1, 1'b0, 64'hBEEF, 64'h0, 1'b1, 8'hC0, 64'h0000_0000_8000_0006, 64'hBEEF_0000_0000_0000, 64'h0, 1'b0};
`ifdef MEM_REQ_INITIATOR_MISALIGN_CHECK_EN
        vecs[3]  = '{64'h0000_0000_8000_0002, 1'b0, 2'd2, 1'b0, 64'h0, 64'hAAAA_BBBB_CCDD_EEFF, 1'b0, 8'h00, 64'h0000_0000_8000_0002, 64'h0, 64'h0, 1'b1};
        vecs[11] = '{64'h0000_0000_8000_0004, 1'b1, 2'd3, 1'b0, 64'hCAFE, 64'h0, 1'b0, 8'h00, 64'h0000_0000_8000_0004, 64'h0, 64'h0, 1'b1};
`else
        vecs[3]  = '{64'h0000_0000_8000_0002, 1'b0, 2'd2, 1'b0, 64'h0, 64'hAAAA_BBBB_CCDD_EEFF, 1'b1, 8'h0F, 64'h0000_0000_8000_0000, 64'h0, 64'h0000_0000_CCDD_EEFF, 1'b0};
        vecs[11] = '{64'h0000_0000_8000_0004, 1'b1, 2'd3, 1'b0, 64'hCAFE, 64'h0, 1'b1, 8'hFF, 64'h0000_0000_8000_0000, 64'hCAFE, 64'h0, 1'b0};
`endif
        vecs[4]  = '{64'h0000_0000_8000_0004, 1'b0, 2'd1, 1'b0, 64'h0, 64'h1234_8765_0000_0000, 1'b1, 8'h30, 64'h0000_0000_8000_0004, 64'h0, 64'h0000_0000_0000_8765, 1'b0};
        vecs[5]  = '{64'h0000_0000_8000_0004, 1'b0, 2'd1, 1'b1, 64'h0, 64'h1234_8765_0000_0000, 1'b1, 8'h30, 64'h0000_0000_8000_0004, 64'h0, 64'hFFFF_FFFF_FFFF_8765, 1'b0};
        vecs[6]  = '{64'h0000_0000_8000_0004, 1'b0, 2'd2, 1'b1, 64'h0, 64'h9ABC_DEF0_1111_2222, 1'b1, 8'hF0, 64'h0000_0000_8000_0004, 64'h0, 64'hFFFF_FFFF_9ABC_DEF0, 1'b0};
        vecs[7]  = '{64'h0000_0000_8000_0007, 1'b0, 2'd0, 1'b0, 64'h0, 64'hFE00_0000_0000_0000, 1'b1, 8'h80, 64'h0000_0000_8000_0007, 64'h0, 64'h0000_0000_0000_00FE, 1'b0};
        vecs[8]  = '{64'h0000_0000_0000_0010, 1'b1, 2'd3, 1'b0, 64'h0123_4567_89AB_CDEF, 64'h0, 1'b1, 8'hFF, 64'h0000_0000_0000_0010, 64'h0123_4567_89AB_CDEF, 64'h0, 1'b0};
        vecs[9]  = '{64'h0000_0000_0000_0005, 1'b1, 2'd0, 1'b0, 64'h0000_0000_0000_00A5, 64'h0, 1'b1, 8'h20, 64'h0000_0000_0000_0005, 64'h0000_A500_0000_0000, 64'h0, 1'b0};
        vecs[10] = '{64'h0000_0000_0000_0000, 1'b0, 2'd2, 1'b1, 64'h0, 64'h0000_0000_7FFF_FFFF, 1'b1, 8'h0F, 64'h0000_0000_0000_0000, 64'h0, 64'h0000_0000_7FFF_FFFF, 1'b0};

        // Power-on reset with a command offered: nothing may be accepted.
        rst_i                 = 1'b1;
        rsp_ready_i           = 1'b1;
        data_if_data_rvalid_i = 1'b0;
        data_if_data_rdata_i  = 64'h0;
        cur_mem               = 64'h0;
        cur_exp               = '{rdata: 64'h0, err: 1'b0};
        set_cmd(64'h8000_0000, 1'b1, 2'd3, 1'b0, 64'hFFFF);
        repeat (2) @(posedge clk_i);
        #1;
        check_reset("por");
        tick();
        rst_i       = 1'b0;
        cmd_valid_i = 1'b0;
        #1;
        chk("idle_cmd_ready", 64'(cmd_ready_o), 64'd1);
        chk("idle_rsp_valid", 64'(rsp_valid_o), 64'd0);

        // Table vectors, each offered as soon as the DUT can take it.
        foreach (vecs[i]) begin
            set_cmd(vecs[i].addr, vecs[i].we, vecs[i].size, vecs[i].sgn, vecs[i].wdata);
            cur_mem = vecs[i].mem;
            cur_exp = '{rdata: vecs[i].exp_rdata, err: vecs[i].exp_err};
            #1;
            for (int w = 0; w < 20 && !cmd_ready_o; w++) begin
                tick();
                #1;
            end
            chk($sformatf("v%0d_cmd_ready", i), 64'(cmd_ready_o), 64'd1);
            chk($sformatf("v%0d_req", i), 64'(data_if_data_req_o), 64'(vecs[i].exp_req));
            chk($sformatf("v%0d_be", i), 64'(data_if_data_be_o), 64'(vecs[i].exp_be));
            chk($sformatf("v%0d_addr", i), data_if_address_o, vecs[i].exp_addr);
            chk($sformatf("v%0d_we", i), 64'(data_if_data_we_o), 64'(vecs[i].we & vecs[i].exp_req));
            if (vecs[i].we && vecs[i].exp_req)
                chk($sformatf("v%0d_wdata", i), data_if_data_wdata_o, vecs[i].exp_wdata);
            tick();
        end
        cmd_valid_i = 1'b0;
        repeat (6) tick();
        chk("drain_queue_empty", 64'(exp_q.size()), 64'd0);
        #1;
        chk("drain_rsp_valid", 64'(rsp_valid_o), 64'd0);

        // Backpressure: two loads fill the buffer, the third waits until one
        // cycle after the first response is popped.
        exp_rdy     = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        rsp_ready_i = 1'b0;
        k           = 0;
        for (int i = 0; i < 5; i++) begin
            set_cmd(64'h100 + 64'(8 * k), 1'b0, 2'd3, 1'b0, 64'h0);
            cur_mem = 64'h5000 + 64'(k);
            cur_exp = '{rdata: 64'h5000 + 64'(k), err: 1'b0};
            if (i == 3) rsp_ready_i = 1'b1;
            #1;
            chk($sformatf("bp%0d_cmd_ready", i), 64'(cmd_ready_o), 64'(exp_rdy[i]));
            if (i == 1) chk("bp_rsp_not_yet", 64'(rsp_valid_o), 64'd0);
            if (i == 2) chk("bp_rsp_two_cycles", 64'(rsp_valid_o), 64'd1);
            acc = cmd_ready_o;
            tick();
            if (acc) k++;
        end
        cmd_valid_i = 1'b0;
        repeat (6) tick();
        chk("bp_accepted", 64'(k), 64'd3);
        chk("bp_queue_empty", 64'(exp_q.size()), 64'd0);

        // Reset mid-operation: one response buffered, one load in flight.
        rsp_ready_i = 1'b0;
        set_cmd(64'h200, 1'b0, 2'd3, 1'b0, 64'h0);
        cur_mem = 64'hDEAD_0001;
        cur_exp = '{rdata: 64'hDEAD_0001, err: 1'b0};
        #1;
        tick();
        cmd_valid_i = 1'b0;
        tick();
        set_cmd(64'h208, 1'b0, 2'd3, 1'b0, 64'h0);
        cur_mem = 64'hDEAD_0002;
        cur_exp = '{rdata: 64'hDEAD_0002, err: 1'b0};
        #1;
        chk("rst_seq_issue", 64'(data_if_data_req_o), 64'd1);
        tick();
        rst_i = 1'b1;
        exp_q.delete();
        #1;
        check_reset("mid");
        tick();
        rst_i                 = 1'b0;
        cmd_valid_i           = 1'b0;
        rsp_ready_i           = 1'b1;
        data_if_data_rvalid_i = 1'b1;
        data_if_data_rdata_i  = 64'hBAD0_BAD0_BAD0_BAD0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("post_rst%0d_rsp_valid", i), 64'(rsp_valid_o), 64'd0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
